// File: rtl/mem_access_sequencer_if.sv
// Bundle of arbiter grants, per-requester commands, memory port and completion signals
// shared by the memory access sequencer and whatever drives or observes it.
interface mem_access_sequencer_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic            grant1;
    logic            grant2;
    logic            grant3;
    logic [3*AW-1:0] req_addr;
    logic [3*DW-1:0] req_wdata;
    logic [2:0]      req_we;
    logic            mem_cs;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic [2:0]      done;
    logic [DW-1:0]   rdata;
    logic            busy;
    logic            err;

    modport slave (
        input  grant1, grant2, grant3, req_addr, req_wdata, req_we, mem_rdata,
        output mem_cs, mem_we, mem_addr, mem_wdata, done, rdata, busy, err
    );

    modport master (
        output grant1, grant2, grant3, req_addr, req_wdata, req_we, mem_rdata,
        input  mem_cs, mem_we, mem_addr, mem_wdata, done, rdata, busy, err
    );
endinterface

// File: rtl/mem_access_sequencer.sv
// Serialises one-hot arbiter grants into single-port memory accesses, one in flight,
// returning a one-hot done pulse and read data to the served requester.
module mem_access_sequencer #(
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_access_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(RD_LAT - 1);

    function automatic logic grant_multi_hot(input logic [2:0] g);
        return (g & (g - 3'b001)) != 3'b000;
    endfunction

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic [2:0]    idx_q;
    logic          mem_cs_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [2:0]    done_q;
    logic [DW-1:0] rdata_q;
    logic          busy_q;
    logic          err_q;

    logic [2:0]    grant_s;
    logic          multi_s;
    logic          one_hot_s;
    logic [AW-1:0] sel_addr_s;
    logic [DW-1:0] sel_wdata_s;
    logic          sel_we_s;

    assign grant_s   = {bus.grant3, bus.grant2, bus.grant1};
    assign multi_s   = grant_multi_hot(grant_s);
    assign one_hot_s = (grant_s != 3'b000) && !multi_s;

    // Route the command fields of the single granted requester.
    always_comb begin
        sel_addr_s  = {AW{1'b0}};
        sel_wdata_s = {DW{1'b0}};
        sel_we_s    = 1'b0;
        case (grant_s)
            3'b001: begin
                sel_addr_s  = bus.req_addr[AW-1:0];
                sel_wdata_s = bus.req_wdata[DW-1:0];
                sel_we_s    = bus.req_we[0];
            end
            3'b010: begin
                sel_addr_s  = bus.req_addr[2*AW-1:AW];
                sel_wdata_s = bus.req_wdata[2*DW-1:DW];
                sel_we_s    = bus.req_we[1];
            end
            3'b100: begin
                sel_addr_s  = bus.req_addr[3*AW-1:2*AW];
                sel_wdata_s = bus.req_wdata[3*DW-1:2*DW];
                sel_we_s    = bus.req_we[2];
            end
            default: begin
                sel_addr_s  = {AW{1'b0}};
                sel_wdata_s = {DW{1'b0}};
                sel_we_s    = 1'b0;
            end
        endcase
    end

    // Access FSM; every output is registered and strobes default low each cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            idx_q       <= 3'b000;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {AW{1'b0}};
            mem_wdata_q <= {DW{1'b0}};
            done_q      <= 3'b000;
            rdata_q     <= {DW{1'b0}};
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mem_cs_q <= 1'b0;
            done_q   <= 3'b000;
            err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (one_hot_s) begin
                        idx_q       <= grant_s;
                        mem_addr_q  <= sel_addr_s;
                        mem_wdata_q <= sel_wdata_s;
                        mem_we_q    <= sel_we_s;
                        mem_cs_q    <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ISSUE;
                    end else if (multi_s) begin
                        err_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    mem_we_q <= 1'b0;
                    if (mem_we_q) begin
                        done_q  <= idx_q;
                        state_q <= RESP;
                    end else begin
                        cnt_q   <= WAIT_LOAD;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // Counter stops at zero: that cycle carries valid read data.
                    if (cnt_q == 4'd0) begin
                        rdata_q <= bus.mem_rdata;
                        done_q  <= idx_q;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    state_q <= GAP;
                end
                GAP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_cs    = mem_cs_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.done      = done_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_mem_access_sequencer.sv
// Drives two sequencers (RD_LAT 2 and 1) with identical grant traffic and compares them
// against a transaction-level model built from the latency/throughput rules.
module tb_mem_access_sequencer;
    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int LAT0 = 2;
    localparam int LAT1 = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_access_sequencer_if #(.AW(AW), .DW(DW)) bus0 ();
    mem_access_sequencer_if #(.AW(AW), .DW(DW)) bus1 ();

    mem_access_sequencer #(.AW(AW), .DW(DW), .RD_LAT(LAT0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    mem_access_sequencer #(.AW(AW), .DW(DW), .RD_LAT(LAT1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    logic [2:0]      grant_drv;
    logic [3*AW-1:0] addr_drv;
    logic [3*DW-1:0] wdata_drv;
    logic [2:0]      we_drv;
    logic [DW-1:0]   rdata_drv [2];

    assign bus0.grant1 = grant_drv[0];
    assign bus0.grant2 = grant_drv[1];
    assign bus0.grant3 = grant_drv[2];
    assign bus0.req_addr = addr_drv;
    assign bus0.req_wdata = wdata_drv;
    assign bus0.req_we = we_drv;
    assign bus0.mem_rdata = rdata_drv[0];
    assign bus1.grant1 = grant_drv[0];
    assign bus1.grant2 = grant_drv[1];
    assign bus1.grant3 = grant_drv[2];
    assign bus1.req_addr = addr_drv;
    assign bus1.req_wdata = wdata_drv;
    assign bus1.req_we = we_drv;
    assign bus1.mem_rdata = rdata_drv[1];

    logic          o_cs   [2];
    logic          o_we   [2];
    logic          o_busy [2];
    logic          o_err  [2];
    logic [2:0]    o_done [2];
    logic [AW-1:0] o_addr [2];
    logic [DW-1:0] o_wdata[2];
    logic [DW-1:0] o_rdata[2];

    assign o_cs[0] = bus0.mem_cs;      assign o_cs[1] = bus1.mem_cs;
    assign o_we[0] = bus0.mem_we;      assign o_we[1] = bus1.mem_we;
    assign o_busy[0] = bus0.busy;      assign o_busy[1] = bus1.busy;
    assign o_err[0] = bus0.err;        assign o_err[1] = bus1.err;
    assign o_done[0] = bus0.done;      assign o_done[1] = bus1.done;
    assign o_addr[0] = bus0.mem_addr;  assign o_addr[1] = bus1.mem_addr;
    assign o_wdata[0] = bus0.mem_wdata; assign o_wdata[1] = bus1.mem_wdata;
    assign o_rdata[0] = bus0.rdata;    assign o_rdata[1] = bus1.rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: last accepted transaction plus the next cycle grants are sampled.
    int         lat      [2];
    int         free_at  [2];
    int         rec_s    [2];
    logic       rec_valid[2];
    logic       rec_we   [2];
    logic [2:0] rec_idx  [2];
    logic [7:0] rec_addr [2];
    logic [7:0] rec_wdata[2];
    logic [7:0] rec_rval [2];
    int         err_s    [2];
    logic [7:0] rdata_exp[2];
    logic [7:0] ref_mem  [2][256];
    // Environment memory answering the DUT's own memory port.
    logic [7:0] ram      [2][256];
    int         pend_t   [2];
    logic [7:0] pend_v   [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset(input int k, input int c);
        free_at[k]   = c;
        rec_valid[k] = 1'b0;
        rec_s[k]     = -100;
        rec_we[k]    = 1'b0;
        err_s[k]     = -100;
        rdata_exp[k] = 8'h00;
        pend_t[k]    = -1;
    endtask

    task automatic model_accept(input int k, input int c);
        int r;
        if (c >= free_at[k] && grant_drv != 3'b000) begin
            if ($countones(grant_drv) == 1) begin
                r = grant_drv[0] ? 0 : (grant_drv[1] ? 1 : 2);
                rec_valid[k] = 1'b1;
                rec_s[k]     = c;
                rec_idx[k]   = grant_drv;
                rec_we[k]    = we_drv[r];
                rec_addr[k]  = addr_drv[r*AW +: AW];
                rec_wdata[k] = wdata_drv[r*DW +: DW];
                if (rec_we[k]) begin
                    ref_mem[k][rec_addr[k]] = rec_wdata[k];
                    free_at[k] = c + 4;
                end else begin
                    rec_rval[k] = ref_mem[k][rec_addr[k]];
                    free_at[k] = c + 4 + lat[k];
                end
            end else begin
                err_s[k] = c;
            end
        end
    endtask

    task automatic check_outputs(input int k, input int c);
        int   done_c;
        logic exp_cs;
        done_c = rec_s[k] + 2 + (rec_we[k] ? 0 : lat[k]);
        exp_cs = rec_valid[k] && (c == rec_s[k] + 1);
        if (rec_valid[k] && !rec_we[k] && c == done_c) rdata_exp[k] = rec_rval[k];
        check_eq($sformatf("busy%0d", k), 32'(o_busy[k]),
                 32'(rec_valid[k] && c > rec_s[k] && c < free_at[k]));
        check_eq($sformatf("mem_cs%0d", k), 32'(o_cs[k]), 32'(exp_cs));
        check_eq($sformatf("done%0d", k), 32'(o_done[k]),
                 32'((rec_valid[k] && c == done_c) ? rec_idx[k] : 3'b000));
        check_eq($sformatf("err%0d", k), 32'(o_err[k]), 32'(c == err_s[k] + 1));
        check_eq($sformatf("rdata%0d", k), 32'(o_rdata[k]), 32'(rdata_exp[k]));
        check_eq($sformatf("mem_addr%0d", k), 32'(o_addr[k]), 32'(rec_valid[k] ? rec_addr[k] : 8'h00));
        check_eq($sformatf("mem_wdata%0d", k), 32'(o_wdata[k]), 32'(rec_valid[k] ? rec_wdata[k] : 8'h00));
        if (exp_cs) check_eq($sformatf("mem_we%0d", k), 32'(o_we[k]), 32'(rec_we[k]));
    endtask

    task automatic respond(input int k, input int c);
        if (o_cs[k]) begin
            if (o_we[k]) begin
                ram[k][o_addr[k]] = o_wdata[k];
            end else begin
                pend_t[k] = c + lat[k];
                pend_v[k] = ram[k][o_addr[k]];
            end
        end
        rdata_drv[k] = (pend_t[k] == c) ? pend_v[k] : 8'($urandom);
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            check_outputs(k, cyc);
            respond(k, cyc);
        end
    endtask

    task automatic drive(input logic [2:0] g, input logic [2:0] we, input logic [23:0] a,
                         input logic [23:0] d, input int hold);
        for (int i = 0; i < hold; i++) begin
            grant_drv = g;
            we_drv    = we;
            addr_drv  = a;
            wdata_drv = d;
            for (int k = 0; k < 2; k++) model_accept(k, cyc);
            step();
        end
    endtask

    task automatic random_traffic(input int n);
        logic [2:0]  g;
        logic [23:0] a;
        int          r;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 99);
            if (r < 35) g = 3'b000;
            else if (r < 85) g = 3'(3'b001 << $urandom_range(0, 2));
            else g = 3'(($urandom_range(0, 3) == 0) ? 3'b111 : (3'b111 ^ (3'b001 << $urandom_range(0, 2))));
            a = {4'h0, 4'($urandom), 4'h0, 4'($urandom), 4'h0, 4'($urandom)};
            drive(g, 3'($urandom), a, 24'($urandom), $urandom_range(1, 6));
        end
    endtask

    initial begin
        logic [7:0] v;
        lat[0] = LAT0;
        lat[1] = LAT1;
        reset = 1'b0;
        grant_drv = 3'b000;
        we_drv = 3'b000;
        addr_drv = 24'h0;
        wdata_drv = 24'h0;
        for (int k = 0; k < 2; k++) begin
            rdata_drv[k] = 8'h00;
            for (int a = 0; a < 256; a++) begin
                v = 8'($urandom);
                ram[k][a] = v;
                ref_mem[k][a] = v;
            end
            ram[k][8'h10] = 8'h5A;
            ref_mem[k][8'h10] = 8'h5A;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("rst_busy%0d", k), 32'(o_busy[k]), 32'd0);
            check_eq($sformatf("rst_cs%0d", k), 32'(o_cs[k]), 32'd0);
            check_eq($sformatf("rst_done%0d", k), 32'(o_done[k]), 32'd0);
            check_eq($sformatf("rst_err%0d", k), 32'(o_err[k]), 32'd0);
            check_eq($sformatf("rst_rdata%0d", k), 32'(o_rdata[k]), 32'd0);
            model_reset(k, 0);
        end
        reset = 1'b1;
        cyc = 0;

        // Directed scenarios: write, read of 5A, illegal grant, held grant then grant1.
        drive(3'b010, 3'b010, 24'h003C00, 24'h00A500, 1);
        drive(3'b000, 3'b000, 24'h0, 24'h0, 6);
        drive(3'b001, 3'b000, 24'h000010, 24'h0, 1);
        drive(3'b000, 3'b000, 24'h0, 24'h0, 8);
        drive(3'b101, 3'b000, 24'h200010, 24'h0, 1);
        drive(3'b000, 3'b000, 24'h0, 24'h0, 3);
        drive(3'b100, 3'b000, 24'h3C0000, 24'h0, 6);
        drive(3'b001, 3'b001, 24'h000077, 24'h0000C3, 1);
        drive(3'b000, 3'b000, 24'h0, 24'h0, 8);

        random_traffic(300);

        // Reset while both sequencers sit in WAIT.
        drive(3'b000, 3'b000, 24'h0, 24'h0, 8);
        drive(3'b001, 3'b000, 24'h000010, 24'h0, 1);
        drive(3'b000, 3'b000, 24'h0, 24'h0, 1);
        reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("midrst_busy%0d", k), 32'(o_busy[k]), 32'd0);
            check_eq($sformatf("midrst_cs%0d", k), 32'(o_cs[k]), 32'd0);
            check_eq($sformatf("midrst_done%0d", k), 32'(o_done[k]), 32'd0);
            check_eq($sformatf("midrst_rdata%0d", k), 32'(o_rdata[k]), 32'd0);
        end
        @(negedge clk);
        cyc++;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) model_reset(k, cyc);

        random_traffic(100);
        drive(3'b000, 3'b000, 24'h0, 24'h0, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
